// File: rtl/batalha_naval_jogo.sv
`default_nettype none
// ============================================================================
// Module   : batalha_naval_jogo
// Brief    : Battleship game controller: fleet placement, alternating shots,
//            registered hit/miss/err pulses and winner. Optional macro
//            BATALHA_TIRO_EXTRA_EN grants an extra shot after a non-final hit.
// Revision : 1.0 - initial release
// ============================================================================
module batalha_naval_jogo #(
    parameter int NUM_SHIPS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] pos,
    input  logic       place,
    input  logic       fire,
    output logic       turn_p2,
    output logic       hit,
    output logic       miss,
    output logic       err,
    output logic [3:0] ships_p1,
    output logic [3:0] ships_p2,
    output logic       game_over,
    output logic       winner_p2
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLACE_P1  = 3'd1,
        S_PLACE_P2  = 3'd2,
        S_TURN_P1   = 3'd3,
        S_TURN_P2   = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam logic [3:0] c_num_ships = 4'(NUM_SHIPS);
`ifdef BATALHA_TIRO_EXTRA_EN
    localparam logic c_extra_shot = 1'b1;
`else
    localparam logic c_extra_shot = 1'b0;
`endif

    state_t     r_state;
    logic [7:0] r_grid_p1;
    logic [7:0] r_grid_p2;

    logic       w_cell_p1;
    logic       w_cell_p2;
    logic [3:0] w_inc_p1;
    logic [3:0] w_inc_p2;

    assign w_cell_p1 = r_grid_p1[pos];
    assign w_cell_p2 = r_grid_p2[pos];
    assign w_inc_p1  = ships_p1 + 4'd1;
    assign w_inc_p2  = ships_p2 + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grid_p1 <= 8'd0;
            r_grid_p2 <= 8'd0;
            turn_p2   <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            err       <= 1'b0;
            ships_p1  <= 4'd0;
            ships_p2  <= 4'd0;
            game_over <= 1'b0;
            winner_p2 <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_PLACE_P1;
                        turn_p2 <= 1'b0;
                    end
                end
                S_PLACE_P1: begin
                    if (place) begin
                        if (w_cell_p1) begin
                            err <= 1'b1;
                        end else begin
                            r_grid_p1[pos] <= 1'b1;
                            ships_p1       <= w_inc_p1;
                            if (w_inc_p1 == c_num_ships) begin
                                r_state <= S_PLACE_P2;
                                turn_p2 <= 1'b1;
                            end
                        end
                    end
                end
                S_PLACE_P2: begin
                    if (place) begin
                        if (w_cell_p2) begin
                            err <= 1'b1;
                        end else begin
                            r_grid_p2[pos] <= 1'b1;
                            ships_p2       <= w_inc_p2;
                            if (w_inc_p2 == c_num_ships) begin
                                r_state <= S_TURN_P1;
                                turn_p2 <= 1'b0;
                            end
                        end
                    end
                end
                S_TURN_P1: begin
                    // Player 1 shoots at player 2's fleet.
                    if (fire) begin
                        if (w_cell_p2) begin
                            hit            <= 1'b1;
                            r_grid_p2[pos] <= 1'b0;
                            ships_p2       <= ships_p2 - 4'd1;
                            if (ships_p2 == 4'd1) begin
                                r_state   <= S_GAME_OVER;
                                game_over <= 1'b1;
                                winner_p2 <= 1'b0;
                            end else if (!c_extra_shot) begin
                                r_state <= S_TURN_P2;
                                turn_p2 <= 1'b1;
                            end
                        end else begin
                            miss    <= 1'b1;
                            r_state <= S_TURN_P2;
                            turn_p2 <= 1'b1;
                        end
                    end
                end
                S_TURN_P2: begin
                    if (fire) begin
                        if (w_cell_p1) begin
                            hit            <= 1'b1;
                            r_grid_p1[pos] <= 1'b0;
                            ships_p1       <= ships_p1 - 4'd1;
                            if (ships_p1 == 4'd1) begin
                                r_state   <= S_GAME_OVER;
                                game_over <= 1'b1;
                                winner_p2 <= 1'b1;
                            end else if (!c_extra_shot) begin
                                r_state <= S_TURN_P1;
                                turn_p2 <= 1'b0;
                            end
                        end else begin
                            miss    <= 1'b1;
                            r_state <= S_TURN_P1;
                            turn_p2 <= 1'b0;
                        end
                    end
                end
                S_GAME_OVER: begin
                    // turn_p2 keeps the last shooter until a new game starts.
                    if (start) begin
                        r_state   <= S_PLACE_P1;
                        r_grid_p1 <= 8'd0;
                        r_grid_p2 <= 8'd0;
                        ships_p1  <= 4'd0;
                        ships_p2  <= 4'd0;
                        game_over <= 1'b0;
                        winner_p2 <= 1'b0;
                        turn_p2   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_batalha_naval_jogo.sv
`default_nettype none
// ============================================================================
// Module   : tb_batalha_naval_jogo
// Brief    : Table-driven and randomized checks of batalha_naval_jogo against
//            a game-rule reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_batalha_naval_jogo;

    localparam int NUM_SHIPS = 3;
`ifdef BATALHA_TIRO_EXTRA_EN
    localparam bit c_extra = 1'b1;
`else
    localparam bit c_extra = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] pos = 3'd0;
    logic       place = 1'b0;
    logic       fire = 1'b0;
    logic       turn_p2, hit, miss, err, game_over, winner_p2;
    logic [3:0] ships_p1, ships_p2;

    int n_checks = 0;
    int n_fail   = 0;

    batalha_naval_jogo #(.NUM_SHIPS(NUM_SHIPS)) dut (
        .clk(clk), .rst(rst), .start(start), .pos(pos), .place(place),
        .fire(fire), .turn_p2(turn_p2), .hit(hit), .miss(miss), .err(err),
        .ships_p1(ships_p1), .ships_p2(ships_p2), .game_over(game_over),
        .winner_p2(winner_p2)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 placing, 2 shooting, 3 over.
    int phase, actor;
    bit board[2][8];
    bit m_hit, m_miss, m_err, m_win;

    function automatic int live(input int p);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(board[p][i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++) board[p][i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        phase = 0; actor = 0; m_win = 0;
        m_hit = 0; m_miss = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit s, input int p, input bit pl, input bit f);
        int opp;
        m_hit = 0; m_miss = 0; m_err = 0;
        case (phase)
            0: if (s) begin phase = 1; actor = 0; model_clear(); end
            1: if (pl) begin
                if (board[actor][p]) m_err = 1;
                else begin
                    board[actor][p] = 1;
                    if (live(actor) == NUM_SHIPS) begin
                        if (actor == 0) actor = 1;
                        else begin actor = 0; phase = 2; end
                    end
                end
            end
            2: if (f) begin
                opp = 1 - actor;
                if (board[opp][p]) begin
                    m_hit = 1;
                    board[opp][p] = 0;
                    if (live(opp) == 0) begin phase = 3; m_win = (actor == 1); end
                    else if (!c_extra) actor = opp;
                end else begin
                    m_miss = 1;
                    actor = opp;
                end
            end
            default: if (s) begin
                model_clear(); phase = 1; actor = 0; m_win = 0;
            end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("hit", int'(hit), int'(m_hit));
        chk("miss", int'(miss), int'(m_miss));
        chk("err", int'(err), int'(m_err));
        chk("turn_p2", int'(turn_p2), actor);
        chk("ships_p1", int'(ships_p1), live(0));
        chk("ships_p2", int'(ships_p2), live(1));
        chk("game_over", int'(game_over), int'(phase == 3));
        chk("winner_p2", int'(winner_p2), int'(m_win));
    endtask

    task automatic cyc(input bit s, input logic [2:0] p, input bit pl, input bit f);
        @(negedge clk);
        start = s; pos = p; place = pl; fire = f;
        @(posedge clk);
        model_edge(s, int'(p), pl, f);
        #1;
        check_model();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
        start = 0; place = 0; fire = 0;
    endtask

    typedef struct {
        bit s; logic [2:0] p; bit pl; bit f;
        bit h; bit m; bit e; bit t;
        logic [3:0] s1; logic [3:0] s2; bit go; bit w;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit s, logic [2:0] p, bit pl, bit f, bit h, bit m,
                                bit e, bit t, logic [3:0] s1, logic [3:0] s2,
                                bit go, bit w);
        vec_t v;
        v.s = s; v.p = p; v.pl = pl; v.f = f; v.h = h; v.m = m; v.e = e;
        v.t = t; v.s1 = s1; v.s2 = s2; v.go = go; v.w = w;
        return v;
    endfunction

    initial begin
        int p2_tgt[3];
        int k;
        bit done;
        model_reset();

        tbl.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,1,0, 0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(0,4,1,0, 0,0,0,0, 2,0,0,0));
        tbl.push_back(mk(0,4,1,0, 0,0,1,0, 2,0,0,0));
        tbl.push_back(mk(0,6,1,0, 0,0,0,1, 3,0,0,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,1, 3,1,0,0));
        tbl.push_back(mk(0,2,1,0, 0,0,0,1, 3,2,0,0));
        tbl.push_back(mk(0,7,1,0, 0,0,0,0, 3,3,0,0));
        if (!c_extra) begin
            tbl.push_back(mk(0,2,0,1, 1,0,0,1, 3,2,0,0));
            tbl.push_back(mk(0,3,0,1, 0,1,0,0, 3,2,0,0));
            tbl.push_back(mk(0,2,0,1, 0,1,0,1, 3,2,0,0));
            tbl.push_back(mk(0,5,0,1, 0,1,0,0, 3,2,0,0));
            tbl.push_back(mk(0,0,0,1, 1,0,0,1, 3,1,0,0));
            tbl.push_back(mk(0,5,0,1, 0,1,0,0, 3,1,0,0));
        end else begin
            tbl.push_back(mk(0,2,0,1, 1,0,0,0, 3,2,0,0));
            tbl.push_back(mk(0,3,0,1, 0,1,0,1, 3,2,0,0));
            tbl.push_back(mk(0,5,0,1, 0,1,0,0, 3,2,0,0));
            tbl.push_back(mk(0,2,0,1, 0,1,0,1, 3,2,0,0));
            tbl.push_back(mk(0,5,0,1, 0,1,0,0, 3,2,0,0));
            tbl.push_back(mk(0,0,0,1, 1,0,0,0, 3,1,0,0));
        end
        tbl.push_back(mk(0,7,0,1, 1,0,0,0, 3,0,1,0));
        tbl.push_back(mk(0,3,0,1, 0,0,0,0, 3,0,1,0));
        tbl.push_back(mk(1,3,1,1, 0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,3,1,1, 0,0,0,0, 1,0,0,0));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;

        // Reach TURN_P2 with player 1 down to two ships, then reset mid-cycle.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0); cyc(0, 2, 1, 0); cyc(0, 3, 1, 0);
        cyc(0, 4, 1, 0); cyc(0, 5, 1, 0); cyc(0, 6, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        if (actor == 0) cyc(0, 7, 0, 1);
        chk("pre_reset_turn", int'(turn_p2), 1);
        chk("pre_reset_ships_p1", int'(ships_p1), 2);
        async_reset();
        chk("reset_ships_p1", int'(ships_p1), 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].pl, tbl[i].f);
            chk($sformatf("tbl%0d_hit", i), int'(hit), int'(tbl[i].h));
            chk($sformatf("tbl%0d_miss", i), int'(miss), int'(tbl[i].m));
            chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e));
            chk($sformatf("tbl%0d_turn", i), int'(turn_p2), int'(tbl[i].t));
            chk($sformatf("tbl%0d_s1", i), int'(ships_p1), int'(tbl[i].s1));
            chk($sformatf("tbl%0d_s2", i), int'(ships_p2), int'(tbl[i].s2));
            chk($sformatf("tbl%0d_go", i), int'(game_over), int'(tbl[i].go));
            chk($sformatf("tbl%0d_win", i), int'(winner_p2), int'(tbl[i].w));
        end

        // P1 fleet {3,5,6}, P2 fleet {0,1,4}; P1 hits 4, then P2 sinks all.
        cyc(0, 5, 1, 0); cyc(0, 6, 1, 0);
        cyc(0, 0, 1, 0); cyc(0, 1, 1, 0); cyc(0, 4, 1, 0);
        cyc(0, 4, 0, 1);
        chk("extra_hit", int'(hit), 1);
        chk("extra_turn_after_hit", int'(turn_p2), c_extra ? 0 : 1);
        p2_tgt[0] = 3; p2_tgt[1] = 5; p2_tgt[2] = 6;
        k = 0;
        done = 0;
        if (c_extra) begin
            cyc(0, 7, 0, 1);
            chk("extra_turn_after_miss", int'(turn_p2), 1);
        end
        for (int n = 0; n < 20 && !done; n++) begin
            if (actor == 0) cyc(0, 7, 0, 1);
            else begin cyc(0, 3'(p2_tgt[k]), 0, 1); k = (k + 1) % 3; end
            done = game_over;
        end
        chk("p2_game_done", int'(done), 1);
        chk("p2_winner", int'(winner_p2), 1);

        // Randomized play against the reference model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            else cyc($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/batalha_naval_jogo.md
Name: batalha_naval_jogo

Overview:
Sequential game controller for the battleship (batalha naval) datapath. It registers each player's fleet on an 8-cell board (3-bit positions), alternates turns, and resolves each shot against the opponent's fleet. It produces registered hit/miss results and declares the winner. It is the shot-issuing and scoring side that drives and consumes the per-shot hit/miss comparison.

Parameters:
NUM_SHIPS, 3, ships per player (legal range 1..8); each ship occupies one cell.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begins placement from IDLE; restarts the game from GAME_OVER
pos  input  3  cell index 0..7 for placement or shot
place  input  1  placement strobe, one cycle, honoured only in PLACE_P1/PLACE_P2
fire  input  1  shot strobe, one cycle, honoured only in TURN_P1/TURN_P2
turn_p2  output  1  0 = player 1 acts, 1 = player 2 acts (placement or shot)
hit  output  1  one-cycle pulse: last shot hit a live ship
miss  output  1  one-cycle pulse: last shot missed
err  output  1  one-cycle pulse: rejected placement (cell already occupied)
ships_p1  output  4  live ships remaining for player 1
ships_p2  output  4  live ships remaining for player 2
game_over  output  1  level, high in GAME_OVER
winner_p2  output  1  valid when game_over: 0 = player 1 won, 1 = player 2 won

Behaviour:
- Reset (async, rst=1) forces state IDLE and clears both 8-bit fleet grids. All outputs go to 0: turn_p2, hit, miss, err, ships_p1, ships_p2, game_over, winner_p2. Reset mid-game abandons the game completely.
- All outputs are registered. A strobe sampled at edge N produces its pulse and any state or count change during the cycle after edge N (latency 1). Pulses last exactly one cycle.
- States: IDLE, PLACE_P1, PLACE_P2, TURN_P1, TURN_P2, GAME_OVER.
- IDLE: start moves to PLACE_P1. place and fire are ignored.
- PLACE_Px, place=1:
  - If grid_x[pos]=0: set the bit and increment ships_x.
  - If grid_x[pos]=1: err pulse; grid and count unchanged.
  - When the increment reaches NUM_SHIPS, transition on the same edge: PLACE_P1 -> PLACE_P2, PLACE_P2 -> TURN_P1.
- TURN_Px, fire=1, checked against the opponent grid grid_y:
  - grid_y[pos]=1: hit pulse, clear grid_y[pos], decrement ships_y.
  - grid_y[pos]=0: miss pulse. This includes a repeat shot on an already-sunk cell.
  - After any shot the turn passes to the other player, except as modified by the optional feature.
  - If the decrement makes ships_y=0, go to GAME_OVER on the same edge. game_over=1, and winner_p2 = 1 if the shooter was player 2. The hit pulse is still asserted.
- turn_p2 is 1 in PLACE_P2 and TURN_P2, and 0 otherwise. In GAME_OVER it holds its last value.
- GAME_OVER: fire and place are ignored. start clears both grids and counts, clears game_over and winner_p2, and enters PLACE_P1.
- Simultaneous strobes: only the strobe relevant to the current state is acted on; the other is ignored. start is ignored outside IDLE and GAME_OVER.
- No pulse is produced for an ignored strobe. hit, miss and err are never asserted together.
- Counts saturate by construction: never above NUM_SHIPS, never below 0.

Optional Feature:
- Macro BATALHA_TIRO_EXTRA_EN.
- When defined: a hit that does not end the game keeps the turn with the shooter, so the same player fires again. A miss passes the turn as normal.
- When undefined: the turn always alternates after every shot.

Test Plan:
1. Reset mid-TURN_P2 with ships_p1=2 -> all outputs 0 and state IDLE immediately. Next start -> PLACE_P1 with empty grids.
2. NUM_SHIPS=3. P1 places 1,4,4,6 -> err pulse on the second 4; ships_p1=3 and turn_p2=1 on the cycle after place(6). P2 places 0,2,7 -> TURN_P1, turn_p2=0.
3. P1 fires 2 -> hit, ships_p2=2, turn_p2=1. P2 fires 3 -> miss, turn_p2=0. P1 fires 2 again -> miss, ships_p2 stays 2.
4. Continue with P1 firing 0 and then 7, with P2 missing in between -> the cycle after the last shot shows hit=1, ships_p2=0, game_over=1, winner_p2=0. A further fire produces no pulse.
5. From GAME_OVER, pulse start with place=1 and fire=1 in the same cycle -> PLACE_P1, counts 0, game_over=0, no err/hit/miss. With BATALHA_TIRO_EXTRA_EN defined: P1 hits at 4 and turn_p2 remains 0; P1 then misses and turn_p2=1.
